regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the ares-riscv core. It is the successor to the single-write, two-read register file. It adds configurable width, depth and read-port count, and a second write port (ALU writeback plus load writeback). It also adds a busy-bit scoreboard for pipeline hazard detection and a post-reset initialisation sequencer that loads every entry deterministically. It sits between decode (read and reserve) and writeback (write and release).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- SP_IDX, 2, index loaded with SP_INIT during init
- FP_IDX, 8, index loaded with SP_INIT during init
- SP_INIT, 32'h0000_0000, init value for SP_IDX/FP_IDX (all other entries init to 0)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- ready_o  out  1  high once initialisation is complete
- we0_i  in  1  write port 0 enable
- waddr0_i  in  ADDR_W  write port 0 address
- wdata0_i  in  DATA_W  write port 0 data
- we1_i  in  1  write port 1 enable (priority over port 0)
- waddr1_i  in  ADDR_W  write port 1 address
- wdata1_i  in  DATA_W  write port 1 data
- raddr_i  in  NUM_RD*ADDR_W  read addresses; port k is at bits [k*ADDR_W +: ADDR_W]
- rdata_o  out  NUM_RD*DATA_W  read data, packed the same way as raddr_i
- rbusy_o  out  NUM_RD  per-port scoreboard busy flag
- rsv_en_i  in  1  reserve request (marks destination pending)
- rsv_addr_i  in  ADDR_W  address to reserve

## Operation
- FSM states: INIT, RUN.
- Reset (rst_i=0, async) forces:
  - state=INIT, init counter=0, ready_o=0
  - all busy bits cleared
  - storage contents are don't-care until INIT completes
- INIT:
  - Each rising edge writes entry[cnt] with its init value: SP_INIT for SP_IDX/FP_IDX, otherwise 0. Then cnt increments.
  - When cnt==DEPTH-1 is written, the next state is RUN and ready_o becomes 1.
  - we0/we1/rsv_en are ignored.
  - rdata_o all 0 and rbusy_o all 0.
- RUN, writes:
  - A port writes on a rising edge when we*_i=1 and waddr*_i!=0.
  - Both ports writing the same address: port 1 data is stored.
  - Writes to address 0 are discarded.
- RUN, reads (combinational):
  - Address 0 returns 0.
  - Otherwise, an enabled nonzero write to the same address in the same cycle is bypassed: port 1 data has priority over port 0.
  - Otherwise the stored value is returned.
- RUN, scoreboard:
  - busy[a] is set on the edge where rsv_en_i=1 and rsv_addr_i=a!=0.
  - busy[a] is cleared on the edge where either write port writes a.
  - Reserve and write to the same address on the same edge: reserve wins, and busy stays/becomes 1 (new producer).
  - busy[0] is always 0.
- rbusy_o[k] = busy[raddr_k] AND NOT (a same-cycle write to raddr_k). When the write is bypassed, the operand is available.
- Reset mid-operation aborts everything and restarts INIT from entry 0.

## Timing
- Read latency is 0 cycles (combinational from raddr, waddr, we and wdata).
- Write-to-read: same cycle via bypass, or next cycle from storage.
- Reserve: rbusy_o reflects the reservation from the cycle after the reserve edge.
- Init takes exactly DEPTH rising edges after rst_i deasserts. ready_o is high after the DEPTH-th edge (32 for default parameters).
- Reset value of every output:
  - ready_o=0
  - rdata_o=0
  - rbusy_o=0

## Test plan
- Release reset, hold we=0 -> ready_o rises after exactly 32 edges. Then reading x2 and x8 returns SP_INIT, and x1/x5/x31 return 0.
- RUN: we0 writes x5=32'hDEAD_BEEF while raddr port0=5 -> rdata port0 is DEAD_BEEF in the same cycle and the following cycle.
- we0 x7=32'h1111_1111 and we1 x7=32'h2222_2222 on the same edge -> read x7 returns 2222_2222 both during the bypass cycle and afterwards.
- Write x0=32'hFFFF_FFFF and reserve x0 -> x0 reads 0 and rbusy is 0.
- Reserve x9, then read x9 -> rbusy=1 from the next cycle. Write x9=32'h0000_00AA -> rbusy=0 that cycle with data AA. Reserve+write x9 on the same edge -> rbusy=1 afterwards.
- Assert rst_i mid-INIT (cnt=10) and mid-RUN with busy bits set, and issue writes during INIT -> ready_o drops immediately, busy bits clear, init restarts and takes 32 edges, and INIT-time writes have no effect.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, NUM_RD combinational read
// ports with write bypass, busy-bit scoreboard, and a post-reset init sequencer.
// Latency: reads 0 cycles; writes and reserves take effect on the next rising edge.
// Backpressure: none. Callers must hold off on ready_o; writes and reserves in INIT are dropped.
//
// Ports:
//   clk_i, rst_i (async, active-low)    clock and reset
//   ready_o                             initialisation complete
//   we0_i/waddr0_i/wdata0_i             write port 0
//   we1_i/waddr1_i/wdata1_i             write port 1 (wins over port 0)
//   raddr_i, rdata_o, rbusy_o           packed read ports, k at [k*W +: W]
//   rsv_en_i, rsv_addr_i                scoreboard reserve (mark pending)
module regfile_mp #(
  parameter int                 DATA_W  = 32,
  parameter int                 ADDR_W  = 5,
  parameter int                 NUM_RD  = 2,
  parameter int                 SP_IDX  = 2,
  parameter int                 FP_IDX  = 8,
  parameter logic [DATA_W-1:0]  SP_INIT = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     ready_o,
  input  logic                     we0_i,
  input  logic [ADDR_W-1:0]        waddr0_i,
  input  logic [DATA_W-1:0]        wdata0_i,
  input  logic                     we1_i,
  input  logic [ADDR_W-1:0]        waddr1_i,
  input  logic [DATA_W-1:0]        wdata1_i,
  input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
  output logic [NUM_RD*DATA_W-1:0] rdata_o,
  output logic [NUM_RD-1:0]        rbusy_o,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i
);

  localparam int                DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] SP_A  = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] FP_A  = ADDR_W'(FP_IDX);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              wen0, wen1;
  logic [DATA_W-1:0] init_val;

  assign run     = (state_q == RUN);
  assign ready_o = run;

  // Effective write strobes: only in RUN, and never to x0.
  assign wen0 = run && we0_i && (waddr0_i != '0);
  assign wen1 = run && we1_i && (waddr1_i != '0);

  assign init_val = (cnt_q == SP_A || cnt_q == FP_A) ? SP_INIT : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q;
      end
      default: state_d = INIT;
    endcase
  end

  // Scoreboard: writes release, then a reserve re-claims, so a reserve on the
  // same edge as the releasing write leaves the entry pending for the new producer.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (wen0) busy_d[waddr0_i] = 1'b0;
      if (wen1) busy_d[waddr1_i] = 1'b0;
      if (rsv_en_i && rsv_addr_i != '0) busy_d[rsv_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Storage has no reset; INIT overwrites every entry. Port 1 is assigned last
  // so it wins a same-address collision.
  always_ff @(posedge clk_i) begin
    if (!run) begin
      mem[cnt_q] <= init_val;
    end else begin
      if (wen0) mem[waddr0_i] <= wdata0_i;
      if (wen1) mem[waddr1_i] <= wdata1_i;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0, hit1;

    assign ra   = raddr_i[k*ADDR_W +: ADDR_W];
    assign hit0 = wen0 && (waddr0_i == ra);
    assign hit1 = wen1 && (waddr1_i == ra);

    assign rdata_o[k*DATA_W +: DATA_W] = (!run || ra == '0) ? '0       :
                                         hit1               ? wdata1_i :
                                         hit0               ? wdata0_i :
                                                              mem[ra];

    // A same-cycle write satisfies the pending operand through the bypass.
    assign rbusy_o[k] = run && busy_q[ra] && !(hit0 || hit1);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: init timing, bypass, write priority,
// x0 handling, scoreboard reserve/release, and reset mid-INIT / mid-RUN.
module tb_regfile_mp;

  localparam logic [31:0] SPV = 32'hCAFE_0100;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ready_o;
  logic        we0_i, we1_i, rsv_en_i;
  logic [4:0]  waddr0_i, waddr1_i, rsv_addr_i;
  logic [31:0] wdata0_i, wdata1_i;
  logic [9:0]  raddr_i;
  logic [63:0] rdata_o;
  logic [1:0]  rbusy_o;

  always #5 clk_i = ~clk_i;

  regfile_mp #(
    .DATA_W (32),
    .ADDR_W (5),
    .NUM_RD (2),
    .SP_IDX (2),
    .FP_IDX (8),
    .SP_INIT(SPV)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ready_o   (ready_o),
    .we0_i     (we0_i),
    .waddr0_i  (waddr0_i),
    .wdata0_i  (wdata0_i),
    .we1_i     (we1_i),
    .waddr1_i  (waddr1_i),
    .wdata1_i  (wdata1_i),
    .raddr_i   (raddr_i),
    .rdata_o   (rdata_o),
    .rbusy_o   (rbusy_o),
    .rsv_en_i  (rsv_en_i),
    .rsv_addr_i(rsv_addr_i)
  );

  typedef struct {
    string       tag;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        ready;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] e1, input logic [31:0] e0,
                      input logic [1:0] eb, input logic erdy);
    exp_t e;
    e.tag   = tag;
    e.rdata = {e1, e0};
    e.rbusy = eb;
    e.ready = erdy;
    sb_q.push_back(e);
  endtask

  // Let combinational outputs settle, then compare every queued expectation.
  task automatic drain();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, "_rdata"}, rdata_o, e.rdata);
      check({e.tag, "_rbusy"}, {62'd0, rbusy_o}, {62'd0, e.rbusy});
      check({e.tag, "_ready"}, {63'd0, ready_o}, {63'd0, e.ready});
    end
  endtask

  task automatic drv(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                     input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                     input logic rs, input logic [4:0] ra,
                     input logic [4:0] rp1, input logic [4:0] rp0);
    we0_i = w0; waddr0_i = a0; wdata0_i = d0;
    we1_i = w1; waddr1_i = a1; wdata1_i = d1;
    rsv_en_i = rs; rsv_addr_i = ra;
    raddr_i = {rp1, rp0};
  endtask

  // One RUN cycle: drive at negedge, expect the combinational result before the next posedge.
  task automatic step(input string tag,
                      input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic rs, input logic [4:0] ra,
                      input logic [4:0] rp1, input logic [4:0] rp0,
                      input logic [31:0] e1, input logic [31:0] e0, input logic [1:0] eb);
    @(negedge clk_i);
    drv(w0, a0, d0, w1, a1, d1, rs, ra, rp1, rp0);
    push(tag, e1, e0, eb, 1'b1);
    drain();
  endtask

  // Count rising edges from now until ready_o, bounded.
  task automatic count_init(input string tag, input int expect_edges);
    int edges = 0;
    while (ready_o !== 1'b1 && edges < 100) begin
      @(posedge clk_i);
      edges++;
      #1;
      if (edges == 5) begin
        push({tag, "_during"}, 32'd0, 32'd0, 2'b00, 1'b0);
        drain();
      end
    end
    check({tag, "_edges"}, 64'(edges), 64'(expect_edges));
  endtask

  initial begin
    rst_i = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 5'd8, 5'd2);

    // Reset state
    push("reset", 32'd0, 32'd0, 2'b00, 1'b0);
    drain();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    // Clean init; port reads x8/x2 which are loaded early with SPV
    count_init("init1", 32);

    step("init_sp_fp",  0,0,0, 0,0,0, 0,0, 5'd8,  5'd2, SPV,   SPV,   2'b00);
    step("init_x1_x5",  0,0,0, 0,0,0, 0,0, 5'd5,  5'd1, 32'd0, 32'd0, 2'b00);
    step("init_x31_x0", 0,0,0, 0,0,0, 0,0, 5'd0,  5'd31,32'd0, 32'd0, 2'b00);

    // Bypass and storage read
    step("wr_x5_byp",   1,5'd5,32'hDEAD_BEEF, 0,0,0, 0,0, 5'd9, 5'd5, 32'd0, 32'hDEAD_BEEF, 2'b00);
    step("wr_x5_mem",   0,0,0, 0,0,0, 0,0, 5'd9, 5'd5, 32'd0, 32'hDEAD_BEEF, 2'b00);

    // Dual write collision: port 1 wins
    step("x7_byp", 1,5'd7,32'h1111_1111, 1,5'd7,32'h2222_2222, 0,0, 5'd7, 5'd7, 32'h2222_2222, 32'h2222_2222, 2'b00);
    step("x7_mem", 0,0,0, 0,0,0, 0,0, 5'd7, 5'd7, 32'h2222_2222, 32'h2222_2222, 2'b00);

    // x0 is hardwired
    step("x0_wr",  1,5'd0,32'hFFFF_FFFF, 1,5'd0,32'hFFFF_FFFF, 1,5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00);
    step("x0_aft", 0,0,0, 0,0,0, 0,0, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00);

    // Scoreboard on x9, both read ports
    step("rsv9",      0,0,0, 0,0,0, 1,5'd9, 5'd9, 5'd9, 32'd0, 32'd0, 2'b00);
    step("busy9",     0,0,0, 0,0,0, 0,0,    5'd9, 5'd9, 32'd0, 32'd0, 2'b11);
    step("wr9_byp",   0,0,0, 1,5'd9,32'h0000_00AA, 0,0, 5'd9, 5'd9, 32'hAA, 32'hAA, 2'b00);
    step("wr9_mem",   0,0,0, 0,0,0, 0,0,    5'd9, 5'd9, 32'hAA, 32'hAA, 2'b00);
    step("rsvwr9",    1,5'd9,32'h0000_00BB, 0,0,0, 1,5'd9, 5'd9, 5'd9, 32'hBB, 32'hBB, 2'b00);
    step("rsvwr9_aft",0,0,0, 0,0,0, 0,0,    5'd9, 5'd9, 32'hBB, 32'hBB, 2'b11);
    step("rsv12",     0,0,0, 0,0,0, 1,5'd12,5'd12,5'd9, 32'd0,  32'hBB, 2'b01);
    step("busy12",    0,0,0, 0,0,0, 0,0,    5'd12,5'd9, 32'd0,  32'hBB, 2'b11);

    // Mid-RUN reset: outputs drop asynchronously
    @(negedge clk_i);
    rst_i = 1'b0;
    push("rst_run", 32'd0, 32'd0, 2'b00, 1'b0);
    drain();
    @(negedge clk_i);

    // Init with junk writes/reserves, interrupted at cnt=10
    drv(1, 5'd3, 32'h3333_3333, 1, 5'd4, 32'h4444_4444, 1, 5'd3, 5'd4, 5'd3);
    rst_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    push("rst_init", 32'd0, 32'd0, 2'b00, 1'b0);
    drain();
    @(negedge clk_i);
    rst_i = 1'b1;
    count_init("init2", 32);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 5'd4, 5'd3);

    step("junk_x3_x4", 0,0,0, 0,0,0, 0,0, 5'd4,  5'd3, 32'd0, 32'd0, 2'b00);
    step("clr_x9_x12", 0,0,0, 0,0,0, 0,0, 5'd12, 5'd9, 32'd0, 32'd0, 2'b00);
    step("reinit_sp",  0,0,0, 0,0,0, 0,0, 5'd8,  5'd2, SPV,   SPV,   2'b00);
    step("reinit_x7",  0,0,0, 0,0,0, 0,0, 5'd5,  5'd7, 32'd0, 32'd0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
